// File: rtl/ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_pkg
// Description : Shared extension-mode encodings for the ID/EX immediate path.
// Revision    : 1.0 - initial release
// ============================================================================
package ext_pkg;

    localparam int EXT_OP_W = 3;

    localparam logic [EXT_OP_W-1:0] EXT_ZERO   = 3'd0;
    localparam logic [EXT_OP_W-1:0] EXT_SIGN   = 3'd1;
    localparam logic [EXT_OP_W-1:0] EXT_UPPER  = 3'd2;
    localparam logic [EXT_OP_W-1:0] EXT_BRANCH = 3'd3;
    localparam logic [EXT_OP_W-1:0] EXT_SHAMT  = 3'd4;

    // shamt occupies imm[10:6] in R-type encodings
    localparam int SHAMT_LSB = 6;
    localparam int SHAMT_W   = 5;

    function automatic logic is_reserved(input logic [EXT_OP_W-1:0] op);
        return (op > EXT_SHAMT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_core
// Description : Combinational immediate extender, five modes plus error tag.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_core
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic [IMM_W-1:0]    imm,
    input  logic [EXT_OP_W-1:0] ext_op,
    output logic [DATA_W-1:0]   data,
    output logic                err
);

    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_upper;
    logic [DATA_W-1:0] w_shamt;

    assign w_zext  = {{(DATA_W-IMM_W){1'b0}}, imm};
    assign w_sext  = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign w_upper = {imm, {(DATA_W-IMM_W){1'b0}}};
    assign w_shamt = {{(DATA_W-SHAMT_W){1'b0}}, imm[SHAMT_LSB+SHAMT_W-1:SHAMT_LSB]};

    always_comb begin
        data = '0;
        err  = is_reserved(ext_op);
        case (ext_op)
            EXT_ZERO:   data = w_zext;
            EXT_SIGN:   data = w_sext;
            EXT_UPPER:  data = w_upper;
            // bits pushed past the MSB are intentionally lost
            EXT_BRANCH: data = w_sext << 2;
            EXT_SHAMT:  data = w_shamt;
            default:    data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_pipe
// Description : Registered immediate extension with a two-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_pipe
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IMM_W-1:0]    imm,
    input  logic [EXT_OP_W-1:0] ext_op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_err
);

    logic [DATA_W-1:0] w_ext_data;
    logic              w_ext_err;
    logic              w_xfer_in;
    logic              w_xfer_out;
    logic              w_main_load;

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic              r_main_err;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_skid_err;

    imm_ext_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_core (
        .imm    (imm),
        .ext_op (ext_op),
        .data   (w_ext_data),
        .err    (w_ext_err)
    );

    assign w_xfer_in   = in_valid & ~r_skid_valid;
    assign w_xfer_out  = r_main_valid & out_ready;
    // main is free this cycle when empty or being consumed
    assign w_main_load = w_xfer_out | ~r_main_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_err   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_err   <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_load) begin
            if (r_skid_valid) begin
                // skid full implies in_ready low, so no new beat competes here
                r_main_valid <= 1'b1;
                r_main_data  <= r_skid_data;
                r_main_err   <= r_skid_err;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_xfer_in;
                if (w_xfer_in) begin
                    r_main_data <= w_ext_data;
                    r_main_err  <= w_ext_err;
                end
            end
        end else if (w_xfer_in) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= w_ext_data;
            r_skid_err   <= w_ext_err;
        end
    end

    assign in_ready  = ~r_skid_valid;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign out_err   = r_main_err;

endmodule
`default_nettype wire

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, registered immediate-extension stage for the MIPS pipeline's ID/EX boundary. Converts an IMM_W-bit instruction immediate into a DATA_W-bit operand under one of five extension modes, and tags illegal modes with an error flag. Holds results in a two-entry skid buffer with valid/ready handshakes on both sides, so the stage absorbs an EX-side stall without a combinational ready path. A synchronous flush discards in-flight immediates on branch mispredict or exception.

## Interface
- DATA_W, 32, output operand width; must be >= IMM_W + 2
- IMM_W, 16, immediate field width; must be >= 11 (shamt field lives in imm[10:6])
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous discard of all buffered entries
- in_valid  in  1  imm/ext_op valid this cycle
- in_ready  out  1  stage can accept a beat; registered, equals "skid entry empty"
- imm  in  IMM_W  raw immediate field
- ext_op  in  3  extension mode, see Operation
- out_valid  out  1  out_data/out_err valid
- out_ready  in  1  EX stage accepts the beat
- out_data  out  DATA_W  extended operand
- out_err  out  1  beat carried a reserved ext_op

## Operation
- ext_op 0 ZERO: {zeros, imm}.
- ext_op 1 SIGN: sign-extend imm from bit IMM_W-1.
- ext_op 2 UPPER: imm placed in bits [DATA_W-1 : DATA_W-IMM_W], low bits zero.
- ext_op 3 BRANCH: sign-extend imm, then shift left 2; bits shifted out above DATA_W-1 are dropped.
- ext_op 4 SHAMT: zero-extend imm[10:6].
- ext_op 5-7 reserved: out_data = 0, out_err = 1; the beat still flows and is not dropped.
- Buffer: main entry (drives outputs) plus skid entry.
- Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
- On transfer in, the beat goes to main if main is empty or is being drained in the same cycle; otherwise it goes to skid.
- When main drains and skid is full, skid moves to main in the same cycle.
- Order is strictly FIFO; no beat is duplicated or lost except by flush.
- Flush: both entries invalidated at the next edge. Flush overrides a simultaneous transfer in (that beat is dropped) and a simultaneous transfer out (the handshake still completes for the consumer; the entry is not re-presented).

## Timing
- Reset values: out_valid 0, out_data 0, out_err 0, in_ready 1; both entries empty.
- Latency: a beat accepted at edge N is presented on out_* after edge N (1 cycle), with no bubble when out_ready stays high.
- Sustained throughput: 1 beat per cycle while out_ready = 1.
- out_ready low with main full: the next accepted beat fills skid, and in_ready drops after that edge.
- in_ready is a pure register output; there is no combinational path from out_ready to in_ready.
- out_data and out_err hold stable while out_valid = 1 and out_ready = 0.
- Reset asserted mid-stream: all entries are cleared immediately (asynchronous); the first accept is possible on the first edge after deassertion.
- Flush while empty: no effect; in_ready stays 1.

## Structure
- Shared package ext_pkg holds:
  - ext_op localparams EXT_ZERO = 0, EXT_SIGN = 1, EXT_UPPER = 2, EXT_BRANCH = 3, EXT_SHAMT = 4;
  - the EXT_OP_W = 3 constant.
- Sub-module imm_ext_core: purely combinational (imm, ext_op) -> (data, err), parametrised by DATA_W and IMM_W.
- imm_ext_pipe instantiates one imm_ext_core at its input and stores extended results in the buffer; raw imm is not stored.

## Test plan
- Reset, then one beat per mode with imm = 16'h8004 and out_ready = 1. Required outputs, each one cycle after its accept:
  - ZERO -> 32'h00008004
  - SIGN -> 32'hFFFF8004
  - UPPER -> 32'h80040000
  - BRANCH -> 32'hFFFE0010
  - SHAMT -> 32'h00000000
  - Repeat SHAMT with imm = 16'h07C0 -> 32'h0000001F.
- ext_op = 6, imm = 16'hFFFF -> out_data = 0, out_err = 1; the next beat (SIGN, 16'h0001) -> 32'h00000001, out_err = 0.
- Backpressure: stream beats A, B, C (SIGN of 1, 2, 3) with out_ready = 0.
  - A sits in main, B in skid; in_ready = 0 after B is accepted; C is held by the source.
  - Raise out_ready -> A, B, C emerge in order on consecutive cycles.
- Flush with both entries full and a simultaneous in_valid beat -> out_valid = 0 and in_ready = 1 on the next cycle; none of the three beats ever appears.
- Assert reset asynchronously between edges with main full -> out_valid, out_data and in_ready show 0, 0, 1 before the next clock edge.
- Random valid/ready toggling over 10k beats against a reference model: FIFO order holds, there is no loss or duplication without flush, and out_data is stable while stalled.
